// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_t   : controller FSM state encoding (IDLE, RUN, DONE)
//   SLICE_W   : width of the ripple adder slice reused every cycle
//   idx_width : width of the nibble counter for a given operand length
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int idx_width(input int nibbles);
    return $clog2(nibbles + 1);
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Four-bit ripple-carry adder slice.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry into bit 0
//   Z     : 4-bit sum
//   Cout  : carry out of bit 3
module four_bit_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Z,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    Z    = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Z[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial wide adder: adds two W-bit operands through a single
// four_bit_adder slice, one nibble per clock, LSB nibble first, with a
// registered carry linking successive nibbles.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : request, sampled only while idle
//   A, B, Cin   : operands and carry-in, captured on an accepted start
//   sub         : (only with SUBTRACT_EN) captured with operands; Z = A - B
//   busy        : high from the cycle after accepted start through DONE
//   done        : one-cycle pulse when Z/Cout are valid
//   Z, Cout     : result and final carry, held until the next result
// Build option: define SUBTRACT_EN to add the sub port (Cout=1 means no borrow).
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int IDX_W   = idx_width(NIBBLES),
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
`ifdef SUBTRACT_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Z,
  output logic         Cout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       z_sh;
  logic [W-1:0]       z_nxt;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [W-1:0]       b_load;
  logic               carry_load;
  logic               last;

`ifdef SUBTRACT_EN
  // Two's-complement subtraction: A + ~B + 1.
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : Cin;
`else
  assign b_load     = B;
  assign carry_load = Cin;
`endif

  four_bit_adder u_slice (
    .A    (a_sh[SLICE_W-1:0]),
    .B    (b_sh[SLICE_W-1:0]),
    .Cin  (carry),
    .Z    (slice_sum),
    .Cout (slice_cout)
  );

  // New nibble enters at the top so the LSB nibble ends at bit 0.
  assign z_nxt = (z_sh >> SLICE_W) | (W'(slice_sum) << (W - SLICE_W));
  assign last  = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      z_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Z     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= A;
          b_sh  <= b_load;
          carry <= carry_load;
          idx   <= '0;
          z_sh  <= '0;
        end
        RUN: begin
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          z_sh  <= z_nxt;
          carry <= slice_cout;
          idx   <= idx + IDX_W'(1);
          // Publish on the final nibble so Z/Cout are valid with done.
          if (last) begin
            Z    <= z_nxt;
            Cout <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
